// File: rtl/midilib_nios2_qsys_0_oci_dct_ctrl_if.sv
// Trace-atom packer bus: atom stream in, packed 30-bit words out, plus status.
// Handshakes: a transfer occurs on a rising edge where valid and ready are both 1; valid may not drop or change payload until then.
interface midilib_nios2_qsys_0_oci_dct_ctrl_if;
   logic        atom_valid;
   logic [1:0]  atom;
   logic        atom_ready;
   logic        test_ending;
   logic        out_valid;
   logic        out_ready;
   logic [29:0] dct_buffer;
   logic [3:0]  dct_count;
   logic        test_has_ended;
   logic [15:0] stall_cycles;
   logic [1:0]  state_dbg;

   modport slave (
      input  atom_valid, atom, test_ending, out_ready,
      output atom_ready, out_valid, dct_buffer, dct_count, test_has_ended,
             stall_cycles, state_dbg
   );

   modport master (
      output atom_valid, atom, test_ending, out_ready,
      input  atom_ready, out_valid, dct_buffer, dct_count, test_has_ended,
             stall_cycles, state_dbg
   );
endinterface

// File: rtl/midilib_nios2_qsys_0_oci_dct_ctrl.sv
// Packs up to 15 two-bit trace atoms into a 30-bit word, emits it downstream,
// and flushes the partial word when the test ends.
module midilib_nios2_qsys_0_oci_dct_ctrl (
   input logic clk,
   input logic reset,
   midilib_nios2_qsys_0_oci_dct_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      FILL = 2'd0,
      EMIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [29:0] buf_q, buf_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        end_q, end_d;
   logic        atom_ready_q, atom_ready_d;
   logic        out_valid_q, out_valid_d;
   logic        ended_q, ended_d;
   logic [15:0] stall_q, stall_d;
   logic        accept;

   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      cnt_d   = cnt_q;
      end_d   = end_q;
      stall_d = stall_q;
      accept  = bus.atom_valid & atom_ready_q;

      if (bus.atom_valid && !atom_ready_q && stall_q != 16'hFFFF)
         stall_d = stall_q + 16'd1;

      case (state_q)
         FILL: begin
            if (bus.test_ending)
               end_d = 1'b1;
            // A same-cycle atom lands before the end request is evaluated.
            if (accept) begin
               for (int k = 0; k < 15; k++)
                  if (cnt_q == 4'(k))
                     buf_d[2*k +: 2] = bus.atom;
               cnt_d = cnt_q + 4'd1;
            end
            if (cnt_d == 4'd15 || (end_d && cnt_d != 4'd0))
               state_d = EMIT;
            else if (end_d)
               state_d = DONE;
         end
         EMIT: begin
            if (bus.test_ending)
               end_d = 1'b1;
            if (bus.out_ready) begin
               buf_d   = '0;
               cnt_d   = '0;
               state_d = end_d ? DONE : FILL;
            end
         end
         DONE:    state_d = DONE;
         default: state_d = FILL;
      endcase

      atom_ready_d = (state_d == FILL);
      out_valid_d  = (state_d == EMIT);
      ended_d      = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= FILL;
         buf_q        <= '0;
         cnt_q        <= '0;
         end_q        <= 1'b0;
         atom_ready_q <= 1'b1;
         out_valid_q  <= 1'b0;
         ended_q      <= 1'b0;
         stall_q      <= '0;
      end else begin
         state_q      <= state_d;
         buf_q        <= buf_d;
         cnt_q        <= cnt_d;
         end_q        <= end_d;
         atom_ready_q <= atom_ready_d;
         out_valid_q  <= out_valid_d;
         ended_q      <= ended_d;
         stall_q      <= stall_d;
      end
   end

   assign bus.atom_ready     = atom_ready_q;
   assign bus.out_valid      = out_valid_q;
   assign bus.dct_buffer     = buf_q;
   assign bus.dct_count      = cnt_q;
   assign bus.test_has_ended = ended_q;
   assign bus.stall_cycles   = stall_q;
   assign bus.state_dbg      = state_q;
endmodule

// File: doc/midilib_nios2_qsys_0_oci_dct_ctrl.md
MIDILIB_NIOS2_QSYS_0_OCI_DCT_CTRL -- requirements
Module: midilib_nios2_qsys_0_oci_dct_ctrl

Interface
REQ-001 Single clock domain; reset is synchronous and active-high.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 atom_valid  in  1  trace atom offered this cycle.
REQ-005 atom  in  2  trace atom code.
REQ-006 atom_ready  out  1  controller accepts atom this cycle.
REQ-007 test_ending  in  1  one-or-more-cycle request to flush and terminate trace.
REQ-008 out_valid  out  1  packed word available downstream.
REQ-009 out_ready  in  1  downstream accepts packed word.
REQ-010 dct_buffer  out  30  packed atoms; valid with out_valid, live fill state otherwise.
REQ-011 dct_count  out  4  number of atoms in dct_buffer, 0..15.
REQ-012 test_has_ended  out  1  flush complete; trace terminated.
REQ-013 stall_cycles  out  16  saturating count of cycles with atom_valid=1 and atom_ready=0.

Function
REQ-014 States: FILL, EMIT, DONE; reset enters FILL.
REQ-015 Packing: atom k (0-based) occupies dct_buffer[2k+1:2k]; bits above 2*dct_count are 0.
REQ-016 FILL: atom_ready=1, out_valid=0; accept = atom_valid & atom_ready.
REQ-017 FILL accept: write atom at slot dct_count, dct_count+1.
REQ-018 FILL: accept bringing dct_count to 15 -> EMIT next cycle (latency 1: 15th atom accepted in cycle N, out_valid=1 in N+1).
REQ-019 FILL: test_ending=1 sets end_pending; same-cycle atom is accepted first and included in the flush.
REQ-020 FILL with end_pending: post-update dct_count>0 -> EMIT; dct_count=0 -> DONE.
REQ-021 EMIT: out_valid=1, atom_ready=0; dct_buffer/dct_count held stable until out_ready.
REQ-022 EMIT & out_ready: next cycle dct_buffer=0, dct_count=0; end_pending -> DONE, else FILL.
REQ-023 test_ending during EMIT sets end_pending; the current word completes normally, then DONE.
REQ-024 DONE: test_has_ended=1, atom_ready=0, out_valid=0; remains until reset; test_ending ignored.
REQ-025 stall_cycles increments by 1 each cycle atom_valid=1 & atom_ready=0, including in DONE; saturates at 16'hFFFF with no wrap.
REQ-026 Atoms presented while atom_ready=0 are not consumed; the source holds them.
REQ-027 out_valid, once high, stays high until out_ready=1; dct_buffer does not change while out_valid=1 & out_ready=0.

Reset
REQ-028 Reset values: state FILL, dct_buffer 0, dct_count 0, end_pending 0, out_valid 0, atom_ready 1 (first cycle after reset), test_has_ended 0, stall_cycles 0.
REQ-029 Reset asserted in any state, including EMIT with an unaccepted word, discards buffered atoms; no word is emitted.
REQ-030 Reset has priority over all other inputs in the same cycle.

Verification
REQ-031 Feed 15 atoms of 2'b01 back-to-back with out_ready=1 -> out_valid for 1 cycle, dct_buffer=30'h15555555, dct_count=15, then FILL with count 0.
REQ-032 Feed atoms 2'b11, 2'b10, 2'b01, then pulse test_ending -> out_valid with dct_buffer=30'h0000001B, dct_count=3; next cycle test_has_ended=1.
REQ-033 test_ending with count 0 -> DONE next cycle, no out_valid; later atom_valid=1 -> atom_ready=0 and stall_cycles increments.
REQ-034 Full word with out_ready=0 for 5 cycles and atom_valid=1 -> dct_buffer stable, stall_cycles=5, accepted on out_ready.
REQ-035 14 atoms, then 15th atom and test_ending in the same cycle -> single word, dct_count=15, then DONE.
REQ-036 Reset asserted during EMIT -> next cycle out_valid=0, dct_count=0, stall_cycles=0, state FILL.
